// File: rtl/requant_stream_if.sv
// requant_stream_if: beat-in/beat-out valid/ready bus for requant_stream_top.
// Ports: in_valid/in_ready/in_addr/acc_vec/out_zp/act_min/act_max (input side),
//        out_valid/out_ready/ofm_vec (output side); master drives beats, slave is the block.
interface requant_stream_if #(
  parameter int LANES = 16,
  parameter int AW = 10,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] in_addr;
  logic [LANES*ACC_W-1:0] acc_vec;
  logic [7:0] out_zp;
  logic [OUT_W-1:0] act_min;
  logic [OUT_W-1:0] act_max;
  logic out_valid;
  logic out_ready;
  logic [LANES*OUT_W-1:0] ofm_vec;
  modport master (
    output in_valid, in_addr, acc_vec, out_zp, act_min, act_max, out_ready,
    input in_ready, out_valid, ofm_vec
  );
  modport slave (
    input in_valid, in_addr, acc_vec, out_zp, act_min, act_max, out_ready,
    output in_ready, out_valid, ofm_vec
  );
endinterface

// File: rtl/requant_stream_top.sv
// requant_stream_top: 4-stage pipelined per-channel requantizer (acc*M, rounding shift, zp, clamp).
// Ports: clk, rst_n (async active-low); m_wr_*/e_wr_* load the M/EXP parameter RAMs;
//        bus (slave) carries the accumulator beats in and the saturated activations out.
module requant_stream_top #(
  parameter int LANES = 16,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH),
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_wr_en,
  input  logic [AW-1:0]       m_wr_addr,
  input  logic [LANES*32-1:0] m_wr_data,
  input  logic                e_wr_en,
  input  logic [AW-1:0]       e_wr_addr,
  input  logic [LANES*8-1:0]  e_wr_data,
  requant_stream_if.slave     bus
);
  logic adv, v0, v1, v2;
  logic [LANES*32-1:0] m_ram [DEPTH];
  logic [LANES*8-1:0] e_ram [DEPTH];
  logic [LANES*32-1:0] m_q;
  logic [LANES*8-1:0] e_q;
  logic [LANES*ACC_W-1:0] acc0;
  logic signed [7:0] zp0, zp1, zp2;
  logic signed [OUT_W-1:0] mn0, mn1, mn2, mx0, mx1, mx2;
  logic [LANES*OUT_W-1:0] ofm_n;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  // Read-first RAMs; the read register only loads on adv so its data survives a stall.
  always_ff @(posedge clk) begin
    if (m_wr_en) m_ram[m_wr_addr] <= m_wr_data;
    if (e_wr_en) e_ram[e_wr_addr] <= e_wr_data;
    if (adv) begin
      m_q <= m_ram[bus.in_addr];
      e_q <= e_ram[bus.in_addr];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.ofm_vec <= '0;
      acc0 <= '0;
      {zp0, zp1, zp2} <= '0;
      {mn0, mn1, mn2} <= '0;
      {mx0, mx1, mx2} <= '0;
    end else if (adv) begin
      v0 <= bus.in_valid;
      v1 <= v0;
      v2 <= v1;
      bus.out_valid <= v2;
      bus.ofm_vec <= ofm_n;
      acc0 <= bus.acc_vec;
      zp0 <= bus.out_zp;
      zp1 <= zp0;
      zp2 <= zp1;
      mn0 <= bus.act_min;
      mn1 <= mn0;
      mn2 <= mn1;
      mx0 <= bus.act_max;
      mx1 <= mx0;
      mx2 <= mx1;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [63:0] prod_n, prod1;
    logic signed [9:0] t;
    logic [5:0] s_n, s1;
    logic signed [64:0] pr, r_n, r2;
    logic signed [65:0] y, lo;
    // 65/66-bit intermediates: the rounding add and zp add can exceed int64 before saturation.
    always_comb begin
      prod_n = 64'(signed'(acc0[ACC_W*i +: ACC_W])) * 64'(signed'(m_q[32*i +: 32]));
      t = 10'sd31 - 10'(signed'(e_q[8*i +: 8]));
      s_n = t < 10'sd0 ? 6'd0 : t > 10'sd63 ? 6'd63 : t[5:0];
      pr = 65'(prod1) + (s1 != 6'd0 ? 65'sd1 <<< (s1 - 6'd1) : 65'sd0);
      r_n = s1 != 6'd0 ? pr >>> s1 : 65'(prod1);
      y = 66'(r2) + 66'(zp2);
      lo = y < 66'(mn2) ? 66'(mn2) : y;
    end
    // Max clamp applied last, so act_min > act_max yields act_max.
    assign ofm_n[OUT_W*i +: OUT_W] = lo > 66'(mx2) ? mx2 : lo[OUT_W-1:0];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        prod1 <= '0;
        s1 <= '0;
        r2 <= '0;
      end else if (adv) begin
        prod1 <= prod_n;
        s1 <= s_n;
        r2 <= r_n;
      end
  end
endmodule

// File: tb/tb_requant_stream_top.sv
// tb_requant_stream_top: table vectors plus backpressure, read-during-write and reset sequences, scoreboard-checked.
module tb_requant_stream_top;
  localparam int LANES = 16, AW = 10, ACC_W = 32, OUT_W = 8;
  logic clk = 0, rst_n = 0;
  logic m_wr_en = 0, e_wr_en = 0;
  logic [AW-1:0] m_wr_addr = '0, e_wr_addr = '0;
  logic [LANES*32-1:0] m_wr_data = '0;
  logic [LANES*8-1:0] e_wr_data = '0;
  requant_stream_if #(.LANES(LANES), .AW(AW), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus();
  requant_stream_top #(.LANES(LANES), .DEPTH(1024), .AW(AW), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .e_wr_en(e_wr_en), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct { logic [LANES*OUT_W-1:0] v; int c; bit lat; } item_t;
  typedef struct { int addr; int a0; int a1; int ar; int zp; int mn; int mx; int e0; int e1; int er; } vec_t;
  item_t sb[$];
  int checks = 0, fails = 0, cyc = 0;
  logic [LANES*32-1:0] sh_m [16];
  logic [LANES*8-1:0] sh_e [16];
  logic [LANES*OUT_W-1:0] held;
  bit stall_prev = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] model(int acc, int m, int e, int zp, int mn, int mx);
    longint p, r, y;
    int s;
    p = longint'(acc) * longint'(m);
    s = 31 - e;
    s = s < 0 ? 0 : s > 63 ? 63 : s;
    r = s == 0 ? p : (p >>> s) + ((p >>> (s - 1)) & 64'sd1);
    y = r + longint'(zp);
    if (y < longint'(mn)) y = longint'(mn);
    if (y > longint'(mx)) y = longint'(mx);
    return y[7:0];
  endfunction
  function automatic logic [LANES*OUT_W-1:0] mvec();
    logic [LANES*OUT_W-1:0] r;
    int a;
    a = int'(bus.in_addr[3:0]);
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = model($signed(bus.acc_vec[32*i +: 32]), $signed(sh_m[a][32*i +: 32]),
                          $signed(sh_e[a][8*i +: 8]), $signed(bus.out_zp),
                          $signed(bus.act_min), $signed(bus.act_max));
    return r;
  endfunction
  function automatic logic [LANES*OUT_W-1:0] ev(int e0, int e1, int er);
    logic [LANES*OUT_W-1:0] r;
    int x;
    for (int i = 0; i < LANES; i++) begin
      x = i == 0 ? e0 : i == 1 ? e1 : er;
      r[8*i +: 8] = x[7:0];
    end
    return r;
  endfunction
  task automatic chk(string name, logic [LANES*OUT_W-1:0] act, logic [LANES*OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) stall_prev = 0;
    else begin
      if (bus.out_valid && !bus.out_ready) begin
        chk("in_ready_stall", {127'd0, bus.in_ready}, '0);
        if (stall_prev) chk("stall_hold", bus.ofm_vec, held);
        held = bus.ofm_vec;
        stall_prev = 1;
      end else stall_prev = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: got %h expected no output", bus.ofm_vec);
        end else begin
          it = sb.pop_front();
          chk("ofm_vec", bus.ofm_vec, it.v);
          if (it.lat) chk("latency", 128'(cyc - it.c), 128'd4);
        end
      end
    end
  end
  task automatic tick(input logic [LANES*OUT_W-1:0] tv, input bit use_tv, input bit lat, output bit got);
    @(negedge clk);
    got = bus.in_valid && bus.in_ready;
    if (got) sb.push_back('{v: use_tv ? tv : mvec(), c: cyc, lat: lat});
    if (m_wr_en) sh_m[m_wr_addr[3:0]] = m_wr_data;
    if (e_wr_en) sh_e[e_wr_addr[3:0]] = e_wr_data;
    @(posedge clk);
    #1;
  endtask
  task automatic send(int addr, int a0, int a1, int ar, int zp, int mn, int mx,
                      logic [LANES*OUT_W-1:0] tv, bit use_tv, bit lat);
    bit ok;
    int n;
    n = 0;
    bus.in_valid = 1;
    bus.in_addr = AW'(addr);
    for (int i = 0; i < LANES; i++) bus.acc_vec[32*i +: 32] = i == 0 ? a0 : i == 1 ? a1 : ar;
    bus.out_zp = zp[7:0];
    bus.act_min = mn[7:0];
    bus.act_max = mx[7:0];
    do begin
      tick(tv, use_tv, lat, ok);
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    bus.in_valid = 0;
    m_wr_en = 0;
    e_wr_en = 0;
  endtask
  task automatic wr(int addr, logic [31:0] m, logic [7:0] e);
    bit ok;
    m_wr_en = 1;
    e_wr_en = 1;
    m_wr_addr = AW'(addr);
    e_wr_addr = AW'(addr);
    m_wr_data = {LANES{m}};
    e_wr_data = {LANES{e}};
    tick('0, 1, 0, ok);
    m_wr_en = 0;
    e_wr_en = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end
  initial begin
    vec_t tab[8];
    tab[0] = '{0, 100, 100, 100, -5, -128, 127, 45, 45, 45};
    tab[1] = '{0, 3, -3, 0, 0, -128, 127, 2, -1, 0};
    tab[2] = '{1, 1000000, 1000000, 1000000, 0, -128, 127, 127, 127, 127};
    tab[3] = '{0, -100, -100, -100, 0, 0, 127, 0, 0, 0};
    tab[4] = '{2, 5, -5, 0, 0, -128, 127, 127, -128, 0};
    tab[5] = '{3, -200, 50, 7, 10, -20, 100, -20, 60, 17};
    tab[6] = '{3, 0, 0, 0, 0, 10, -10, -10, -10, -10};
    tab[7] = '{0, 1, -1, 2147483647, 0, -128, 127, 1, 0, 127};
    bus.in_valid = 0;
    bus.in_addr = '0;
    bus.acc_vec = '0;
    bus.out_zp = '0;
    bus.act_min = '0;
    bus.act_max = '0;
    bus.out_ready = 1;
    #2;
    chk("reset_out_valid", {127'd0, bus.out_valid}, '0);
    chk("reset_ofm_vec", bus.ofm_vec, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
    wr(0, 32'h40000000, 8'd0);
    wr(1, 32'h7FFFFFFF, 8'd0);
    wr(2, 32'h40000000, 8'd40);
    wr(3, 32'h40000000, 8'd1);
    wr(7, 32'h40000000, 8'd0);
    foreach (tab[k])
      send(tab[k].addr, tab[k].a0, tab[k].a1, tab[k].ar, tab[k].zp, tab[k].mn, tab[k].mx,
           ev(tab[k].e0, tab[k].e1, tab[k].er), 1, 1);
    drain();
    m_wr_en = 1;
    m_wr_addr = 7;
    m_wr_data = {LANES{32'h20000000}};
    send(7, 100, 100, 100, 0, -128, 127, ev(50, 50, 50), 1, 1);
    send(7, 100, 100, 100, 0, -128, 127, ev(25, 25, 25), 1, 1);
    drain();
    fork
      for (int k = 0; k < 10; k++) send(3, k * 13 - 60, -k * 7, k, 3, -50, 60, '0, 0, 0);
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    for (int k = 0; k < 5; k++) send(0, 100 + 2 * k, -4 * k, k, 1, -128, 127, '0, 0, 1);
    #1 rst_n = 0;
    #1;
    chk("midreset_out_valid", {127'd0, bus.out_valid}, '0);
    chk("midreset_ofm_vec", bus.ofm_vec, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("post_reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
    send(0, 100, 100, 100, -5, -128, 127, ev(45, 45, 45), 1, 1);
    drain();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
